// File: rtl/stereo_core_scheduler_if.sv
// Bus bundle between the audio controller's L/R source and sink ports, the mono
// reverb core, and the stereo scheduler. master = scheduler side.
interface stereo_core_scheduler_if #(
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0] l_src_data;
  logic [DATA_W-1:0] r_src_data;
  logic              l_src_valid;
  logic              r_src_valid;
  logic              l_src_ready;
  logic              r_src_ready;

  logic [DATA_W-1:0] core_in_data;
  logic              core_in_chan;
  logic              core_in_valid;
  logic              core_in_ready;

  logic [DATA_W-1:0] core_out_data;
  logic              core_out_chan;
  logic              core_out_valid;
  logic              core_out_ready;

  logic [DATA_W-1:0] l_sink_data;
  logic [DATA_W-1:0] r_sink_data;
  logic              l_sink_valid;
  logic              r_sink_valid;
  logic              l_sink_ready;
  logic              r_sink_ready;

  modport master (
    input  l_src_data, r_src_data, l_src_valid, r_src_valid,
    output l_src_ready, r_src_ready,
    output core_in_data, core_in_chan, core_in_valid,
    input  core_in_ready,
    input  core_out_data, core_out_chan, core_out_valid,
    output core_out_ready,
    output l_sink_data, r_sink_data, l_sink_valid, r_sink_valid,
    input  l_sink_ready, r_sink_ready
  );

  modport slave (
    output l_src_data, r_src_data, l_src_valid, r_src_valid,
    input  l_src_ready, r_src_ready,
    input  core_in_data, core_in_chan, core_in_valid,
    output core_in_ready,
    output core_out_data, core_out_chan, core_out_valid,
    input  core_out_ready,
    input  l_sink_data, r_sink_data, l_sink_valid, r_sink_valid,
    output l_sink_ready, r_sink_ready
  );
endinterface

// File: rtl/stereo_core_scheduler.sv
// Shares one mono core between the left and right audio channels: captures a stereo
// pair, issues it L-then-R, routes results back per channel, with a dry bypass path.
module stereo_core_scheduler #(
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  stereo_core_scheduler_if.master bus,
  input  logic                   bypass,
  input  logic                   err_clr,
  output logic [3:0]             inflight,
  output logic                   order_err
);

  localparam logic [3:0] MaxInflight = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {StIdle, StIssueL, StIssueR, StBypass} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic              hold_l_valid_q, hold_l_valid_d, hold_r_valid_q, hold_r_valid_d;
  logic [DATA_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic              out_l_valid_q, out_l_valid_d, out_r_valid_q, out_r_valid_d;
  logic              bypass_mode_q, bypass_mode_d;
  logic              expect_chan_q, expect_chan_d;
  logic              order_err_q, order_err_d;
  logic [3:0]        inflight_q, inflight_d;

  logic l_cap, r_cap, issue_l_done, issue_r_done, bypass_copy;
  logic ret_acc, ret_err, write_l, write_r, inc, dec;

  assign bus.l_src_ready    = !hold_l_valid_q;
  assign bus.r_src_ready    = !hold_r_valid_q;
  assign bus.core_out_ready = bus.core_out_chan ? !out_r_valid_q : !out_l_valid_q;
  assign bus.l_sink_data    = out_l_q;
  assign bus.r_sink_data    = out_r_q;
  assign bus.l_sink_valid   = out_l_valid_q;
  assign bus.r_sink_valid   = out_r_valid_q;
  assign inflight           = inflight_q;
  assign order_err          = order_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bypass_mode_q) begin
          state_d = StBypass;
        end else if (hold_l_valid_q && hold_r_valid_q && (inflight_q < MaxInflight)) begin
          state_d = StIssueL;
        end
      end
      StIssueL: if (bus.core_in_ready) state_d = StIssueR;
      StIssueR: if (bus.core_in_ready) state_d = StIdle;
      StBypass: if (!bypass_mode_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.core_in_valid = 1'b0;
    bus.core_in_chan  = 1'b0;
    bus.core_in_data  = '0;
    unique case (state_q)
      StIssueL: begin
        bus.core_in_valid = 1'b1;
        bus.core_in_data  = hold_l_q;
      end
      StIssueR: begin
        bus.core_in_valid = 1'b1;
        bus.core_in_chan  = 1'b1;
        bus.core_in_data  = hold_r_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    l_cap        = bus.l_src_valid && !hold_l_valid_q;
    r_cap        = bus.r_src_valid && !hold_r_valid_q;
    issue_l_done = (state_q == StIssueL) && bus.core_in_ready;
    issue_r_done = (state_q == StIssueR) && bus.core_in_ready;
    ret_acc      = bus.core_out_valid && bus.core_out_ready;
    write_l      = ret_acc && !bus.core_out_chan;
    write_r      = ret_acc && bus.core_out_chan;
    // Late core results may still land while in bypass; they take the output slots first.
    bypass_copy  = (state_q == StBypass) && hold_l_valid_q && hold_r_valid_q &&
                   !out_l_valid_q && !out_r_valid_q && !bus.core_out_valid;

    hold_l_d       = l_cap ? bus.l_src_data : hold_l_q;
    hold_r_d       = r_cap ? bus.r_src_data : hold_r_q;
    hold_l_valid_d = hold_l_valid_q;
    hold_r_valid_d = hold_r_valid_q;
    if (l_cap)                            hold_l_valid_d = 1'b1;
    else if (issue_l_done || bypass_copy) hold_l_valid_d = 1'b0;
    if (r_cap)                            hold_r_valid_d = 1'b1;
    else if (issue_r_done || bypass_copy) hold_r_valid_d = 1'b0;

    out_l_d       = out_l_q;
    out_r_d       = out_r_q;
    out_l_valid_d = out_l_valid_q;
    out_r_valid_d = out_r_valid_q;
    if (write_l) begin
      out_l_d       = bus.core_out_data;
      out_l_valid_d = 1'b1;
    end else if (bypass_copy) begin
      out_l_d       = hold_l_q;
      out_l_valid_d = 1'b1;
    end else if (bus.l_sink_ready) begin
      out_l_valid_d = 1'b0;
    end
    if (write_r) begin
      out_r_d       = bus.core_out_data;
      out_r_valid_d = 1'b1;
    end else if (bypass_copy) begin
      out_r_d       = hold_r_q;
      out_r_valid_d = 1'b1;
    end else if (bus.r_sink_ready) begin
      out_r_valid_d = 1'b0;
    end

    // Mode only switches with the core drained, so a pair never straddles modes.
    bypass_mode_d = bypass_mode_q;
    if (((state_q == StIdle) || (state_q == StBypass)) && (inflight_q == 4'd0)) begin
      bypass_mode_d = bypass;
    end

    ret_err       = ret_acc && ((bus.core_out_chan != expect_chan_q) ||
                                (bus.core_out_chan && (inflight_q == 4'd0)));
    expect_chan_d = ret_acc ? !bus.core_out_chan : expect_chan_q;
    order_err_d   = ret_err ? 1'b1 : (err_clr ? 1'b0 : order_err_q);

    inc = issue_l_done;
    dec = write_r && (inflight_q != 4'd0);
    inflight_d = inflight_q;
    if (inc && !dec)      inflight_d = inflight_q + 4'd1;
    else if (!inc && dec) inflight_d = inflight_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      hold_l_valid_q <= 1'b0;
      hold_r_valid_q <= 1'b0;
      out_l_q        <= '0;
      out_r_q        <= '0;
      out_l_valid_q  <= 1'b0;
      out_r_valid_q  <= 1'b0;
      bypass_mode_q  <= 1'b0;
      expect_chan_q  <= 1'b0;
      order_err_q    <= 1'b0;
      inflight_q     <= 4'd0;
    end else begin
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      hold_l_valid_q <= hold_l_valid_d;
      hold_r_valid_q <= hold_r_valid_d;
      out_l_q        <= out_l_d;
      out_r_q        <= out_r_d;
      out_l_valid_q  <= out_l_valid_d;
      out_r_valid_q  <= out_r_valid_d;
      bypass_mode_q  <= bypass_mode_d;
      expect_chan_q  <= expect_chan_d;
      order_err_q    <= order_err_d;
      inflight_q     <= inflight_d;
    end
  end

endmodule

// File: tb/tb_stereo_core_scheduler.sv
// Scoreboard bench for stereo_core_scheduler: echo core model, per-sink expected queues.
module tb_stereo_core_scheduler;
  localparam int unsigned DW   = 24;
  localparam int unsigned MAXI = 4;
  localparam int          BIG  = 1000000;

  typedef struct {
    logic          chan;
    logic [DW-1:0] data;
    int            due;
  } item_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bypass = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] inflight;
  logic       order_err;

  stereo_core_scheduler_if #(.DATA_W(DW)) bus ();

  stereo_core_scheduler #(.DATA_W(DW), .MAX_INFLIGHT(MAXI)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .bypass    (bypass),
    .err_clr   (err_clr),
    .inflight  (inflight),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  item_t         exp_core[$];
  item_t         core_q[$];
  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];
  int  n_vec = 0, n_err = 0, cyc = 0, n_issued = 0, byp_hits = 0;
  int  rdy_budget = BIG, ret_budget = BIG;
  bit  ret_taken = 1'b0, swap_once = 1'b0, rand_sink = 1'b0, in_bypass = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe handshakes mid-cycle; the transfer completes at the next rising edge.
  initial forever begin
    item_t e;
    @(negedge clk);
    if (reset_n) begin
      if (bus.core_in_valid && in_bypass) byp_hits++;
      if (bus.core_in_valid && bus.core_in_ready) begin
        n_issued++;
        if (rdy_budget > 0) rdy_budget--;
        if (exp_core.size() == 0) begin
          chk("core_in_unexpected", 32'(exp_core.size()), 32'd1);
        end else begin
          e = exp_core.pop_front();
          chk("core_in_chan", 32'(bus.core_in_chan), 32'(e.chan));
          chk("core_in_data", 32'(bus.core_in_data), 32'(e.data));
        end
        e.chan = bus.core_in_chan;
        e.data = bus.core_in_data;
        e.due  = cyc + 2;
        core_q.push_back(e);
      end
      if (bus.core_out_valid && bus.core_out_ready) begin
        ret_taken = 1'b1;
        if (ret_budget > 0) ret_budget--;
      end
      if (bus.l_sink_valid && bus.l_sink_ready) begin
        if (exp_l.size() == 0) chk("l_sink_unexpected", 32'd0, 32'd1);
        else chk("l_sink_data", 32'(bus.l_sink_data), 32'(exp_l.pop_front()));
      end
      if (bus.r_sink_valid && bus.r_sink_ready) begin
        if (exp_r.size() == 0) chk("r_sink_unexpected", 32'd0, 32'd1);
        else chk("r_sink_data", 32'(bus.r_sink_data), 32'(exp_r.pop_front()));
      end
    end
  end

  // Echo core with a 2-cycle return delay, plus sink-ready drivers.
  initial forever begin
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    if (ret_taken) begin
      bus.core_out_valid = 1'b0;
      ret_taken = 1'b0;
    end
    bus.core_in_ready = (rdy_budget > 0);
    bus.l_sink_ready  = rand_sink ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.r_sink_ready  = rand_sink ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!bus.core_out_valid && ret_budget > 0 && core_q.size() > 0) begin
      idx = (swap_once && core_q.size() >= 2) ? 1 : 0;
      if (core_q[idx].due <= cyc) begin
        bus.core_out_chan  = core_q[idx].chan;
        bus.core_out_data  = core_q[idx].data;
        bus.core_out_valid = 1'b1;
        core_q.delete(idx);
        if (idx == 1) swap_once = 1'b0;
      end
    end
  end

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit via_core);
    item_t e;
    bit    lh, rh;
    if (via_core) begin
      e.chan = 1'b0; e.data = l; e.due = 0;
      exp_core.push_back(e);
      e.chan = 1'b1; e.data = r;
      exp_core.push_back(e);
    end
    exp_l.push_back(l);
    exp_r.push_back(r);
    bus.l_src_data  = l;
    bus.r_src_data  = r;
    bus.l_src_valid = 1'b1;
    bus.r_src_valid = 1'b1;
    for (int n = 0; n < 300 && (bus.l_src_valid || bus.r_src_valid); n++) begin
      @(negedge clk);
      lh = bus.l_src_ready;
      rh = bus.r_src_ready;
      tick();
      if (lh) bus.l_src_valid = 1'b0;
      if (rh) bus.r_src_valid = 1'b0;
    end
    if (bus.l_src_valid || bus.r_src_valid) begin
      chk("src_accept_timeout", 32'(bus.l_src_valid | bus.r_src_valid), 32'd0);
      bus.l_src_valid = 1'b0;
      bus.r_src_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 400; n++) begin
      if (exp_l.size() == 0 && exp_r.size() == 0 && exp_core.size() == 0 &&
          core_q.size() == 0 && !bus.core_out_valid && inflight == 4'd0) break;
      tick();
    end
    chk({tag, "_pending"}, 32'(exp_l.size() + exp_r.size() + exp_core.size() + core_q.size()),
        32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.l_src_data = '0; bus.r_src_data = '0; bus.l_src_valid = 1'b0; bus.r_src_valid = 1'b0;
    bus.core_in_ready = 1'b1; bus.core_out_data = '0; bus.core_out_chan = 1'b0;
    bus.core_out_valid = 1'b0; bus.l_sink_ready = 1'b1; bus.r_sink_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_l_src_ready", 32'(bus.l_src_ready), 32'd1);
    chk("rst_r_src_ready", 32'(bus.r_src_ready), 32'd1);
    chk("rst_core_out_ready", 32'(bus.core_out_ready), 32'd1);
    chk("rst_core_in_valid", 32'(bus.core_in_valid), 32'd0);
    chk("rst_core_in_data", 32'(bus.core_in_data), 32'd0);
    chk("rst_sink_valid", {30'd0, bus.l_sink_valid, bus.r_sink_valid}, 32'd0);
    chk("rst_l_sink_data", 32'(bus.l_sink_data), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_order_err", 32'(order_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic pair
    send_pair(24'h123456, 24'hABCDEF, 1'b1);
    drain("basic");
    chk("basic_inflight", 32'(inflight), 32'd0);
    chk("basic_order_err", 32'(order_err), 32'd0);

    // Core input backpressure in ISSUE_L
    rdy_budget = 0;
    send_pair(24'h123456, 24'h654321, 1'b1);
    for (int n = 0; n < 10 && !bus.core_in_valid; n++) tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_core_in_valid", 32'(bus.core_in_valid), 32'd1);
      chk("bp_core_in_data", 32'(bus.core_in_data), 32'h123456);
      chk("bp_core_in_chan", 32'(bus.core_in_chan), 32'd0);
      chk("bp_r_src_ready", 32'(bus.r_src_ready), 32'd0);
      tick();
    end
    rdy_budget = BIG;
    drain("bp");

    // Random data, random sink backpressure
    rand_sink = 1'b1;
    for (int k = 0; k < 6; k++) send_pair(DW'($urandom), DW'($urandom), 1'b1);
    drain("rand");
    rand_sink = 1'b0;

    // Inflight limit
    ret_budget = 0;
    base = n_issued;
    for (int k = 0; k < 5; k++) send_pair(DW'(24'h100 + k), DW'(24'h200 + k), 1'b1);
    repeat (10) tick();
    @(negedge clk);
    chk("lim_inflight", 32'(inflight), MAXI);
    chk("lim_issued", 32'(n_issued - base), 2 * MAXI);
    chk("lim_core_in_valid", 32'(bus.core_in_valid), 32'd0);
    chk("lim_l_src_ready", 32'(bus.l_src_ready), 32'd0);
    tick();
    ret_budget = 2;
    for (int n = 0; n < 50 && (n_issued - base) < 10; n++) tick();
    chk("lim_5th_issued", 32'(n_issued - base), 32'd10);
    chk("lim_inflight_after", 32'(inflight), MAXI);
    ret_budget = BIG;
    drain("lim");
    chk("lim_inflight_end", 32'(inflight), 32'd0);

    // Bypass requested while pairs are outstanding
    ret_budget = 0;
    send_pair(24'h0A0001, 24'h0B0001, 1'b1);
    send_pair(24'h0A0002, 24'h0B0002, 1'b1);
    for (int n = 0; n < 20 && inflight != 4'd2; n++) tick();
    chk("byp_inflight_2", 32'(inflight), 32'd2);
    bypass = 1'b1;
    repeat (4) tick();
    send_pair(24'h0A0003, 24'h0B0003, 1'b1);  // still core mode: inflight never reached 0
    ret_budget = BIG;
    drain("byp_core");
    repeat (4) tick();
    in_bypass = 1'b1;
    send_pair(24'h0C0001, 24'h0D0001, 1'b0);
    @(negedge clk);
    chk("byp_lat_early", {30'd0, bus.l_sink_valid, bus.r_sink_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("byp_lat_n2", {30'd0, bus.l_sink_valid, bus.r_sink_valid}, 32'd3);
    tick();
    send_pair(24'h0C0002, 24'h0D0002, 1'b0);
    drain("byp");
    chk("byp_core_hits", 32'(byp_hits), 32'd0);
    in_bypass = 1'b0;
    bypass = 1'b0;
    repeat (4) tick();
    send_pair(24'h0E0001, 24'h0F0001, 1'b1);
    drain("post_byp");
    chk("pre_order_err", 32'(order_err), 32'd0);

    // Core returns R before L
    swap_once = 1'b1;
    send_pair(24'h111111, 24'h222222, 1'b1);
    drain("order");
    chk("order_err_set", 32'(order_err), 32'd1);
    chk("order_inflight", 32'(inflight), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("order_err_clr", 32'(order_err), 32'd0);

    // Asynchronous reset while stalled in ISSUE_R
    rdy_budget = 1;
    send_pair(24'h333333, 24'h444444, 1'b1);
    for (int n = 0; n < 20 && !(bus.core_in_valid && bus.core_in_chan); n++) tick();
    chk("ar_in_issue_r", {30'd0, bus.core_in_valid, bus.core_in_chan}, 32'd3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_core.delete(); exp_l.delete(); exp_r.delete(); core_q.delete();
    bus.core_out_valid = 1'b0;
    ret_taken = 1'b0;
    swap_once = 1'b0;
    rdy_budget = BIG;
    chk("ar_core_in_valid", 32'(bus.core_in_valid), 32'd0);
    chk("ar_core_in_data", 32'(bus.core_in_data), 32'd0);
    chk("ar_src_ready", {30'd0, bus.l_src_ready, bus.r_src_ready}, 32'd3);
    chk("ar_core_out_ready", 32'(bus.core_out_ready), 32'd1);
    chk("ar_inflight", 32'(inflight), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    send_pair(24'h555555, 24'h666666, 1'b1);
    drain("ar_post");
    chk("ar_post_order_err", 32'(order_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
